// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch unit: PC, fetch buffer, IR and memory read handshake
//
// Purpose: holds the architectural PC, issues one instruction-memory read per
// fetch, buffers the returned word and loads it into the IR on request.
// A PC change while a read is in flight marks that read stale; the read still
// completes on the bus and its data is dropped, then the new PC is fetched.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   write_pc, pc_s  PC update strobe and next-PC select (00 +4, 01 branch, 10 alu_f, 11 none)
//   imm24, alu_f    branch word offset, jump target
//   write_ir        load IR from the fetch buffer
//   mem_req/addr    registered read request and address
//   mem_ack/rdata/err  read completion, data, bus error
//   I, W_IR_valid   instruction register, fetch buffer valid
//   pc, fetch_fault architectural PC, sticky bus-error flag
module inst_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_pc,
  input  logic [1:0]  pc_s,
  input  logic [23:0] imm24,
  input  logic        write_ir,
  input  logic [31:0] alu_f,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  output logic [31:0] I,
  output logic        W_IR_valid,
  output logic [31:0] pc,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_READY = 2'd2} state_e;

  localparam logic [31:0] UNDEF_INSN = 32'hE7F000F0;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] fb_q, fb_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_req_q, mem_req_d;
  logic        need_fetch_q, need_fetch_d;
  logic        stale_q, stale_d;
  logic        fault_q, fault_d;

  logic        pc_eff;
  logic [31:0] pc_target;
  logic [31:0] branch_off;

  assign pc_eff     = write_pc && (pc_s != 2'b11);
  assign branch_off = {{6{imm24[23]}}, imm24, 2'b00};

  always_comb begin
    case (pc_s)
      2'b00:   pc_target = pc_q + 32'd4;
      2'b01:   pc_target = pc_q + 32'd8 + branch_off;
      2'b10:   pc_target = alu_f;
      default: pc_target = pc_q;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= 32'd0;
      ir_q         <= 32'd0;
      fb_q         <= 32'd0;
      mem_addr_q   <= 32'd0;
      mem_req_q    <= 1'b0;
      need_fetch_q <= 1'b1;
      stale_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      fb_q         <= fb_d;
      mem_addr_q   <= mem_addr_d;
      mem_req_q    <= mem_req_d;
      need_fetch_q <= need_fetch_d;
      stale_q      <= stale_d;
      fault_q      <= fault_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    fb_d         = fb_q;
    mem_addr_d   = mem_addr_q;
    mem_req_d    = mem_req_q;
    need_fetch_d = need_fetch_q;
    stale_d      = stale_q;
    fault_d      = fault_q;

    if (pc_eff) begin
      pc_d         = pc_target;
      need_fetch_d = 1'b1;
      fault_d      = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (need_fetch_q) begin
          state_d      = S_REQ;
          mem_req_d    = 1'b1;
          mem_addr_d   = pc_q;
          need_fetch_d = 1'b0;
          // The request just issued targets the old PC; let it complete and
          // drop it, the stale path then refetches from the new PC.
          stale_d      = pc_eff;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (stale_q || pc_eff) begin
            stale_d      = 1'b0;
            need_fetch_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            state_d = S_READY;
            if (mem_err) begin
              fb_d    = UNDEF_INSN;
              fault_d = 1'b1;
            end else begin
              fb_d = mem_rdata;
            end
          end
        end else if (pc_eff) begin
          stale_d = 1'b1;
        end
      end
      S_READY: begin
        if (write_ir) begin
          ir_d = fb_q;
        end
        if (write_ir || pc_eff) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    mem_req     = mem_req_q;
    mem_addr    = mem_addr_q;
    I           = ir_q;
    pc          = pc_q;
    fetch_fault = fault_q;
    W_IR_valid  = (state_q == S_READY);
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch against a transaction-level model
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_pc;
  logic [1:0]  pc_s;
  logic [23:0] imm24;
  logic        write_ir;
  logic [31:0] alu_f;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [31:0] I;
  logic        W_IR_valid;
  logic [31:0] pc;
  logic        fetch_fault;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .write_pc   (write_pc),
    .pc_s       (pc_s),
    .imm24      (imm24),
    .write_ir   (write_ir),
    .alu_f      (alu_f),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err),
    .I          (I),
    .W_IR_valid (W_IR_valid),
    .pc         (pc),
    .fetch_fault(fetch_fault)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: every effective PC write opens a new generation; a read returns
  // useful data only if no PC write happened since it was issued.
  logic [31:0] m_pc, m_I, m_fb, m_addr;
  bit          m_req, m_valid, m_need, m_fault;
  int          m_gen, m_tag;

  task automatic model_reset();
    m_pc = 0; m_I = 0; m_fb = 0; m_addr = 0;
    m_req = 0; m_valid = 0; m_need = 1; m_fault = 0;
    m_gen = 0; m_tag = 0;
  endtask

  function automatic logic [31:0] target(input logic [31:0] cur, input logic [1:0] sel,
                                         input logic [23:0] imm, input logic [31:0] alu);
    longint words;
    words = imm[23] ? longint'(imm) - 64'sd16777216 : longint'(imm);
    case (sel)
      2'd0:    return 32'(cur + 64'd4);
      2'd1:    return 32'(longint'(cur) + 8 + words * 4);
      2'd2:    return alu;
      default: return cur;
    endcase
  endfunction

  task automatic check_all();
    check("mem_req", {31'd0, mem_req}, {31'd0, m_req});
    check("mem_addr", mem_addr, m_addr);
    check("W_IR_valid", {31'd0, W_IR_valid}, {31'd0, m_valid});
    check("pc", pc, m_pc);
    check("I", I, m_I);
    check("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
  endtask

  // Called at a negedge: check, drive, clock, advance model, return at next negedge.
  task automatic step(input bit wpc, input logic [1:0] sel, input logic [23:0] imm,
                      input logic [31:0] alu, input bit wir, input bit ack,
                      input bit err, input logic [31:0] rd);
    bit f;
    check_all();
    write_pc = wpc; pc_s = sel; imm24 = imm; alu_f = alu;
    write_ir = wir; mem_ack = ack; mem_err = err; mem_rdata = rd;
    @(posedge clk);
    f = wpc && (sel != 2'd3);
    if (m_req) begin
      if (ack) begin
        m_req = 0;
        if (m_tag == m_gen && !f) begin
          m_valid = 1;
          m_fb    = err ? 32'hE7F000F0 : rd;
          if (err) m_fault = 1;
        end else begin
          m_need = 1;
        end
      end
    end else if (m_valid) begin
      if (wir) m_I = m_fb;
      if (wir || f) m_valid = 0;
    end else if (m_need) begin
      m_req = 1; m_addr = m_pc; m_tag = m_gen; m_need = 0;
    end
    if (f) begin
      m_pc = target(m_pc, sel, imm, alu);
      m_gen++;
      m_need = 1;
      m_fault = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(0, 2'd0, 24'd0, 32'd0, 0, 0, 0, 32'd0);
  endtask

  task automatic pcw(input logic [1:0] sel, input logic [23:0] imm, input logic [31:0] alu);
    step(1, sel, imm, alu, 0, 0, 0, 32'd0);
  endtask

  // Ack whatever is outstanding until the buffer is valid; returns the address last acked.
  task automatic drain(input bit err, output logic [31:0] addr);
    addr = 32'hDEADBEEF;
    for (int i = 0; i < 20 && !m_valid; i++) begin
      if (mem_req) addr = mem_addr;
      step(0, 2'd0, 24'd0, 32'd0, 0, mem_req, err, $urandom);
    end
    check("drain_valid", {31'd0, W_IR_valid}, 32'd1);
  endtask

  logic [31:0] a;
  logic [31:0] fb_snap;

  initial begin
    rst = 0; write_pc = 0; pc_s = 0; imm24 = 0; write_ir = 0;
    alu_f = 0; mem_ack = 0; mem_err = 0; mem_rdata = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_I", I, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    rst = 1;

    // Zero-wait first fetch from address 0
    idle_step();
    check("first_addr", mem_addr, 32'd0);
    check("first_req", {31'd0, mem_req}, 32'd1);
    step(0, 2'd0, 24'd0, 32'd0, 0, 1, 0, 32'hE3A01005);
    check("first_valid", {31'd0, W_IR_valid}, 32'd1);
    step(0, 2'd0, 24'd0, 32'd0, 1, 0, 0, 32'd0);
    check("first_I", I, 32'hE3A01005);

    // Branch arithmetic with negative and positive offsets
    pcw(2'd2, 24'd0, 32'h100);
    pcw(2'd1, 24'hFFFFFE, 32'd0);
    check("br_neg", pc, 32'h100);
    pcw(2'd1, 24'd3, 32'd0);
    check("br_pos", pc, 32'h114);
    drain(0, a);
    check("br_addr", a, 32'h114);

    // Jump while a delayed read is outstanding
    pcw(2'd0, 24'd0, 32'd0);
    idle_step();
    idle_step();
    pcw(2'd2, 24'd0, 32'h2000);
    idle_step();
    step(0, 2'd0, 24'd0, 32'd0, 0, 1, 0, 32'h12345678);
    check("stale_valid", {31'd0, W_IR_valid}, 32'd0);
    drain(0, a);
    check("jump_addr", a, 32'h2000);

    // Bus error
    pcw(2'd0, 24'd0, 32'd0);
    drain(1, a);
    check("err_fault", {31'd0, fetch_fault}, 32'd1);
    step(0, 2'd0, 24'd0, 32'd0, 1, 0, 0, 32'd0);
    check("err_I", I, 32'hE7F000F0);
    pcw(2'd0, 24'd0, 32'd0);
    check("err_clear", {31'd0, fetch_fault}, 32'd0);

    // PC wrap
    pcw(2'd2, 24'd0, 32'hFFFFFFFC);
    drain(0, a);
    pcw(2'd0, 24'd0, 32'd0);
    check("wrap_pc", pc, 32'd0);
    drain(0, a);
    check("wrap_addr", a, 32'd0);

    // IR load and PC write on the same edge; reserved select has no effect
    fb_snap = m_fb;
    step(1, 2'd0, 24'd0, 32'd0, 1, 0, 0, 32'd0);
    check("dual_I", I, fb_snap);
    check("dual_pc", pc, 32'd4);
    drain(0, a);
    check("dual_addr", a, 32'd4);
    pcw(2'd3, 24'd0, 32'h55);
    check("rsvd_valid", {31'd0, W_IR_valid}, 32'd1);

    // Reset in the middle of a request, then a late ack
    pcw(2'd2, 24'd0, 32'h800);
    idle_step();
    check("pre_rst_req", {31'd0, mem_req}, 32'd1);
    rst = 0;
    #1;
    check("rst_drop_req", {31'd0, mem_req}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1;
    step(0, 2'd0, 24'd0, 32'd0, 0, 1, 0, 32'hBAD0BAD0);
    drain(0, a);
    check("rst_refetch", a, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit ack;
      ack = mem_req ? ($urandom % 2 == 0) : ($urandom % 8 == 0);
      step($urandom % 5 == 0, 2'($urandom), 24'($urandom), $urandom,
           $urandom % 2 == 0, ack, $urandom % 8 == 0, $urandom);
    end
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately, independent of clk.
REQ-003 write_pc  input  1  PC update strobe from controller.
REQ-004 pc_s  input  2  next-PC select: 00 PC+4, 01 branch, 10 alu_f, 11 reserved.
REQ-005 imm24  input  24  branch offset, word units, two's complement.
REQ-006 write_ir  input  1  IR load strobe from controller.
REQ-007 alu_f  input  32  ALU result, used as jump target.
REQ-008 mem_req  output  1  instruction-memory read request, registered.
REQ-009 mem_addr  output  32  read address, registered.
REQ-010 mem_ack  input  1  read data valid / request accepted.
REQ-011 mem_rdata  input  32  read data, sampled only when mem_ack=1.
REQ-012 mem_err  input  1  bus error, qualified by mem_ack.
REQ-013 I  output  32  instruction register feeding the controller.
REQ-014 W_IR_valid  output  1  fetch buffer holds a valid word for the current PC.
REQ-015 pc  output  32  architectural PC.
REQ-016 fetch_fault  output  1  sticky bus-error flag.

Function
REQ-017 FSM states SHALL be IDLE, REQ, READY; internal regs fb[31:0], need_fetch, stale.
REQ-018 IDLE with need_fetch=1 SHALL go to REQ next edge, latch mem_addr<=pc, set mem_req=1, clear need_fetch.
REQ-019 IDLE with need_fetch=0 SHALL remain in IDLE; mem_req=0.
REQ-020 In REQ, mem_req and mem_addr SHALL hold stable until the edge where mem_ack=1; zero-wait ack (same cycle as mem_req) is legal.
REQ-021 On ack with stale=0 and mem_err=0: fb<=mem_rdata, mem_req<=0, go READY.
REQ-022 On ack with stale=0 and mem_err=1: fb<=32'hE7F000F0 (undefined encoding), fetch_fault<=1, go READY.
REQ-023 On ack with stale=1: data discarded, stale<=0, need_fetch<=1, go IDLE.
REQ-024 W_IR_valid SHALL equal (state==READY).
REQ-025 write_ir=1 in READY: I<=fb, go IDLE; write_ir in any other state ignored, I holds.
REQ-026 write_pc=1 with pc_s 00: pc<=pc+4; 01: pc<=pc+8+(sext(imm24)<<2); 10: pc<=alu_f; all modulo 2^32, wrap silently.
REQ-027 write_pc=1 with pc_s 11: pc unchanged, no flush, no other effect.
REQ-028 Effective write_pc (pc_s!=11) SHALL: set need_fetch; clear fetch_fault; in REQ set stale (request completes, never aborted); in READY discard fb and go IDLE.
REQ-029 Simultaneous write_ir and effective write_pc in READY: I<=fb and pc updates on the same edge, go IDLE, need_fetch=1.
REQ-030 Effective write_pc on the same edge as ack in REQ: treat as stale, data discarded.
REQ-031 Latency: from need_fetch set to W_IR_valid=1 SHALL be 2 cycles plus memory wait cycles.

Reset
REQ-032 rst=0 SHALL set pc=0, I=0, fb=0, mem_req=0, mem_addr=0, W_IR_valid=0, fetch_fault=0, stale=0, state=IDLE, need_fetch=1.
REQ-033 Reset mid-request SHALL drop mem_req immediately; a late mem_ack after release while in IDLE SHALL be ignored.
REQ-034 First fetch after reset SHALL be from address 0.

Verification
REQ-035 Reset release, zero-wait memory returning 32'hE3A01005 -> mem_req=1 addr 0 on cycle 2, W_IR_valid=1 cycle 3; write_ir -> I=32'hE3A01005.
REQ-036 pc=0x100, pc_s=01, imm24=24'hFFFFFE, write_pc -> pc=0x100; pc_s=01, imm24=3 -> pc=0x114; next mem_addr=0x114.
REQ-037 Ack delayed 3 cycles, write_pc (pc_s=10, alu_f=0x2000) during wait -> first data discarded, W_IR_valid stays 0, new request at 0x2000.
REQ-038 Ack with mem_err=1 -> fetch_fault=1, write_ir -> I=32'hE7F000F0; next effective write_pc clears fetch_fault.
REQ-039 pc=0xFFFFFFFC, write_pc pc_s=00 -> pc=0x00000000, fetch from 0.
REQ-040 READY with write_ir and write_pc(pc_s=00) same edge -> I loads fb, pc+4, refetch issued; pc_s=11 alone -> W_IR_valid stays 1.
